// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
//
// Sits between the CPU datapath and a 32-bit unsigned iterative divider.
// Accepts DIVU/DIV/MTHI/MTLO from decode. For a signed divide it hands
// magnitudes to the divider and sign-corrects the results afterwards. It stalls
// the pipeline while a divide is in flight and owns the architectural HI/LO
// registers.
//
// Parameters
//   RISE_TIMEOUT    cycles to wait for div_busy_i to rise before re-issuing
//                   the start pulse (1..15)
//   DIVZERO_LO      value written to LO on divide-by-zero
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_ni          asynchronous active-low reset
//   op_valid_i      HI/LO-class instruction presented (sampled in IDLE only)
//   op_code_i       00 DIVU, 01 DIV, 10 MTHI, 11 MTLO
//   rs_data_i       dividend, or source operand for MTHI/MTLO
//   rt_data_i       divisor
//   stall_o         pipeline freeze request (combinational)
//   done_o          one-cycle pulse after a divide has written HI/LO
//   hi_o / lo_o     architectural HI (remainder) / LO (quotient)
//   div_start_o     one-cycle start pulse to the divider
//   div_dividend_o  unsigned dividend magnitude presented to the divider
//   div_divisor_o   unsigned divisor magnitude presented to the divider
//   div_busy_i      divider busy
//   div_q_i         divider quotient, unsigned
//   div_r_i         divider remainder, unsigned
// -----------------------------------------------------------------------------
module hilo_div_ctrl #(
    parameter int unsigned RISE_TIMEOUT = 4,
    parameter logic [31:0] DIVZERO_LO   = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    input  logic [1:0]  op_code_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_busy_i,
    input  logic [31:0] div_q_i,
    input  logic [31:0] div_r_i
);

    typedef enum logic [1:0] {
        OP_DIVU = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SETTLE,
        S_WRITE
    } state_e;

    // Last WAIT_HI cycle before giving up on div_busy_i and re-issuing.
    localparam logic [3:0] TMO_LAST = 4'(RISE_TIMEOUT - 1);

    op_e         op;
    logic        is_divide;

    state_e      state_q,    state_d;
    logic [3:0]  tmo_q,      tmo_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        q_neg_q,    q_neg_d;
    logic        r_neg_q,    r_neg_d;
    logic        zero_q,     zero_d;
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;
    logic        done_q,     done_d;

    assign op        = op_e'(op_code_i);
    assign is_divide = (op == OP_DIVU) || (op == OP_DIV);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d    = state_q;
        tmo_d      = tmo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid_i) begin
                    unique case (op)
                        OP_MTHI: hi_d = rs_data_i;
                        OP_MTLO: lo_d = rs_data_i;
                        default: begin
                            if (rt_data_i == 32'd0) begin
                                // Divider bypassed: keep raw rs for HI.
                                dividend_d = rs_data_i;
                                divisor_d  = 32'd0;
                                q_neg_d    = 1'b0;
                                r_neg_d    = 1'b0;
                                zero_d     = 1'b1;
                                state_d    = S_WRITE;
                            end else if (op == OP_DIV) begin
                                dividend_d = rs_data_i[31] ? (32'd0 - rs_data_i) : rs_data_i;
                                divisor_d  = rt_data_i[31] ? (32'd0 - rt_data_i) : rt_data_i;
                                q_neg_d    = rs_data_i[31] ^ rt_data_i[31];
                                r_neg_d    = rs_data_i[31];
                                zero_d     = 1'b0;
                                state_d    = S_ISSUE;
                            end else begin
                                dividend_d = rs_data_i;
                                divisor_d  = rt_data_i;
                                q_neg_d    = 1'b0;
                                r_neg_d    = 1'b0;
                                zero_d     = 1'b0;
                                state_d    = S_ISSUE;
                            end
                        end
                    endcase
                end
            end

            S_ISSUE: begin
                tmo_d   = 4'd0;
                state_d = S_WAIT_HI;
            end

            S_WAIT_HI: begin
                if (div_busy_i) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    // Divider never acknowledged; pulse start again.
                    state_d = S_ISSUE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end

            S_WAIT_LO: begin
                if (!div_busy_i) state_d = S_SETTLE;
            end

            // Gives the divider's result registers a cycle to update.
            S_SETTLE: state_d = S_WRITE;

            S_WRITE: begin
                if (zero_q) begin
                    hi_d = dividend_q;
                    lo_d = DIVZERO_LO;
                end else begin
                    // Two's-complement negate; 0x8000_0000 wraps onto itself.
                    lo_d = q_neg_q ? (32'd0 - div_q_i) : div_q_i;
                    hi_d = r_neg_q ? (32'd0 - div_r_i) : div_r_i;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tmo_q      <= 4'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // WRITE does not stall: the instruction retires on the edge that writes
    // HI/LO, so a following MFHI/MFLO sees the new values.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_SETTLE: stall_o = 1'b1;
            S_IDLE:  stall_o = op_valid_i && is_divide;
            default: stall_o = 1'b0;
        endcase
        // Reset forces IDLE, but op_valid_i may still be high; keep stall low.
        if (!rst_ni) stall_o = 1'b0;
    end

    assign div_start_o    = (state_q == S_ISSUE);
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
//
// Self-checking bench for hilo_div_ctrl: a table of directed vectors, a few
// hand-written sequences (back-to-back MTHI/MTLO, reset mid-divide) and a
// randomized run checked against an arithmetic reference model. A behavioural
// divider with configurable latency can ignore a number of start pulses, which
// exercises the re-issue path.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;

    localparam int RISE_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall, done, div_start, div_busy;
    logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;

    int checks = 0;
    int failures = 0;

    hilo_div_ctrl #(.RISE_TIMEOUT(RISE_TIMEOUT), .DIVZERO_LO(32'hFFFF_FFFF)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .op_valid_i     (op_valid),
        .op_code_i      (op_code),
        .rs_data_i      (rs_data),
        .rt_data_i      (rt_data),
        .stall_o        (stall),
        .done_o         (done),
        .hi_o           (hi),
        .lo_o           (lo),
        .div_start_o    (div_start),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_busy_i     (div_busy),
        .div_q_i        (div_q),
        .div_r_i        (div_r)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural divider: busy for 'lat' cycles after an accepted start,
    // results valid after busy falls. Starts are ignored while
    // start_cnt < deaf_until.
    // ------------------------------------------------------------------
    int          lat = 32;
    int          deaf_until = 0;
    int          start_cnt = 0;
    int          cnt = 0;
    int          proto_err = 0;
    int          stab_err = 0;
    logic        prev_start;
    logic [31:0] ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy   <= 1'b0;
            cnt        <= 0;
            div_q      <= '0;
            div_r      <= '0;
            prev_start <= 1'b0;
        end else begin
            prev_start <= div_start;
            if (div_start && prev_start) proto_err <= proto_err + 1;
            if (div_start) start_cnt <= start_cnt + 1;
            if (div_busy && (div_dividend !== ma || div_divisor !== mb))
                stab_err <= stab_err + 1;
            if (div_start && start_cnt >= deaf_until) begin
                div_busy <= 1'b1;
                cnt      <= lat - 1;
                ma       <= div_dividend;
                mb       <= div_divisor;
            end else if (div_busy) begin
                if (cnt == 0) begin
                    div_busy <= 1'b0;
                    div_q    <= (mb != 0) ? ma / mb : '1;
                    div_r    <= (mb != 0) ? ma % mb : ma;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  code;
        logic [31:0] rs, rt;
        int          lat, deaf;
        logic [31:0] e_hi, e_lo, e_mag;
        int          e_stall, e_starts;
        logic        e_done;
    } vec_t;

    // Presents one instruction, holds it while stalled, then checks results.
    task automatic run_op(input vec_t v);
        int   stalls, cyc, s0;
        logic st;
        bit   timed_out;
        stalls = 0; cyc = 0; timed_out = 0;
        @(negedge clk);
        lat        = v.lat;
        s0         = start_cnt;
        deaf_until = start_cnt + v.deaf;
        op_valid   = 1'b1;
        op_code    = v.code;
        rs_data    = v.rs;
        rt_data    = v.rt;
        forever begin
            #1 st = stall;
            if (st) stalls++;
            @(posedge clk);
            if (!st) break;
            cyc++;
            if (cyc > 400) begin timed_out = 1; break; end
        end
        if (timed_out) begin
            checks++; failures++;
            $display("FAIL %s timeout: stall still 1 after %0d cycles, required retire", v.name, cyc);
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check({v.name, " hi"},     hi, v.e_hi);
        check({v.name, " lo"},     lo, v.e_lo);
        check({v.name, " done"},   32'(done), 32'(v.e_done));
        check({v.name, " stalls"}, 32'(stalls), 32'(v.e_stall));
        check({v.name, " starts"}, 32'(start_cnt - s0), 32'(v.e_starts));
        if (v.e_starts > 0) check({v.name, " dividend mag"}, ma, v.e_mag);
        @(negedge clk);
        #1 check({v.name, " done pulse end"}, 32'(done), 32'd0);
    endtask

    // Reference: signed/unsigned division in 64-bit arithmetic (truncating),
    // low 32 bits kept, which gives the wrap for 0x8000_0000 / -1.
    task automatic ref_div(input logic [1:0] code, input logic [31:0] rs, rt,
                           output logic [31:0] e_hi, e_lo);
        longint a, b, q, r;
        if (rt == 0) begin
            e_hi = rs; e_lo = 32'hFFFF_FFFF;
        end else begin
            if (code == 2'b01) begin
                a = longint'($signed(rs)); b = longint'($signed(rt));
            end else begin
                a = longint'({32'd0, rs}); b = longint'({32'd0, rt});
            end
            q = a / b;
            r = a % b;
            e_lo = q[31:0];
            e_hi = r[31:0];
        end
    endtask

    function automatic int div_stalls(input int l, input int d);
        return l + 4 + d * (RISE_TIMEOUT + 1);
    endfunction

    vec_t vecs[$];
    vec_t v;
    logic [31:0] mhi, mlo, ehi, elo;

    initial begin
        // ---------------- reset state (op_valid high must not stall)
        op_valid = 1'b1; op_code = 2'b00; rs_data = 32'd5; rt_data = 32'd1;
        #12;
        check("reset stall", 32'(stall), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset div_start", 32'(div_start), 32'd0);
        check("reset dividend", div_dividend, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table
        vecs.push_back('{"divu 100/7", 2'b00, 32'd100, 32'd7, 32, 0, 32'd2, 32'd14, 32'd100, 36, 1, 1'b1});
        vecs.push_back('{"div -7/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 36, 1, 1'b1});
        vecs.push_back('{"div 7/-2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32, 0, 32'd1, 32'hFFFF_FFFD, 32'd7, 36, 1, 1'b1});
        vecs.push_back('{"div ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32, 0, 32'd0, 32'h8000_0000, 32'h8000_0000, 36, 1, 1'b1});
        vecs.push_back('{"divu by 0", 2'b00, 32'h1234, 32'd0, 32, 0, 32'h1234, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b1});
        vecs.push_back('{"div by 0", 2'b01, 32'h8765_4321, 32'd0, 32, 0, 32'h8765_4321, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b1});
        vecs.push_back('{"mthi", 2'b10, 32'h1111_2222, 32'd0, 32, 0, 32'h1111_2222, 32'hFFFF_FFFF, 32'd0, 0, 0, 1'b0});
        vecs.push_back('{"mtlo", 2'b11, 32'h3333_4444, 32'd9, 32, 0, 32'h1111_2222, 32'h3333_4444, 32'd0, 0, 0, 1'b0});
        vecs.push_back('{"divu retry", 2'b00, 32'd1000, 32'd7, 5, 1, 32'd6, 32'd142, 32'd1000, div_stalls(5, 1), 2, 1'b1});
        vecs.push_back('{"div -100/-7", 2'b01, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 3, 0, 32'hFFFF_FFFE, 32'd14, 32'd100, 7, 1, 1'b1});
        vecs.push_back('{"divu lat1", 2'b00, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1, 1'b1});
        foreach (vecs[i]) run_op(vecs[i]);

        // ---------------- back-to-back MTHI / MTLO, then DIVU 9/3
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'b10; rs_data = 32'hDEAD_BEEF;
        #1 check("mthi b2b stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("mthi b2b hi", hi, 32'hDEAD_BEEF);
        op_code = 2'b11; rs_data = 32'h0000_CAFE;
        #1 check("mtlo b2b stall", 32'(stall), 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        check("mtlo b2b lo", lo, 32'h0000_CAFE);
        check("mtlo b2b hi kept", hi, 32'hDEAD_BEEF);
        run_op('{"divu 9/3", 2'b00, 32'd9, 32'd3, 32, 0, 32'd0, 32'd3, 32'd9, 36, 1, 1'b1});

        // ---------------- reset in the 10th cycle of a divide
        @(negedge clk);
        lat = 32; deaf_until = start_cnt;
        op_valid = 1'b1; op_code = 2'b00; rs_data = 32'd1000; rt_data = 32'd3;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst stall", 32'(stall), 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst dividend", div_dividend, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst idle stall", 32'(stall), 32'd0);
        check("post rst done", 32'(done), 32'd0);
        run_op('{"divu 50/5", 2'b00, 32'd50, 32'd5, 32, 0, 32'd0, 32'd10, 32'd50, 36, 1, 1'b1});

        // ---------------- randomized against reference model
        mhi = hi; mlo = lo;
        for (int n = 0; n < 60; n++) begin
            int sel;
            v.name = $sformatf("rand%0d", n);
            v.code = 2'($urandom_range(0, 3));
            v.rs   = $urandom;
            if ($urandom_range(0, 7) == 0) v.rs = 32'h8000_0000;
            sel = $urandom_range(0, 9);
            if (sel == 0)      v.rt = 32'd0;
            else if (sel == 1) v.rt = 32'hFFFF_FFFF;
            else if (sel == 2) v.rt = 32'($urandom_range(1, 15));
            else               v.rt = $urandom;
            v.lat  = $urandom_range(1, 40);
            v.deaf = 0;
            v.e_mag = '0;
            if (v.code == 2'b10) begin
                mhi = v.rs; v.e_stall = 0; v.e_starts = 0; v.e_done = 1'b0;
            end else if (v.code == 2'b11) begin
                mlo = v.rs; v.e_stall = 0; v.e_starts = 0; v.e_done = 1'b0;
            end else begin
                ref_div(v.code, v.rs, v.rt, ehi, elo);
                mhi = ehi; mlo = elo; v.e_done = 1'b1;
                if (v.rt == 0) begin
                    v.e_stall = 1; v.e_starts = 0;
                end else begin
                    v.deaf     = ($urandom_range(0, 3) == 0) ? 1 : 0;
                    v.e_stall  = div_stalls(v.lat, v.deaf);
                    v.e_starts = 1 + v.deaf;
                    v.e_mag    = (v.code == 2'b01 && v.rs[31]) ? 32'd0 - v.rs : v.rs;
                end
            end
            v.e_hi = mhi; v.e_lo = mlo;
            run_op(v);
        end

        check("div_start protocol", 32'(proto_err), 32'd0);
        check("operand stability", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
